// File: rtl/dds_pkg.sv
// dds_pkg: default sizes, sequencer state encoding and clog2 helper for quarter_wave_dds
package dds_pkg;
    localparam int ACC_W_DEF  = 24;
    localparam int ADDR_W_DEF = 10;
    localparam int NCH_DEF    = 4;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/quarter_fold.sv
// quarter_fold: maps the top ADDR_W+2 phase bits onto a quarter-wave ROM address and sign
module quarter_fold #(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W+1:0] q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              neg
);
    logic [ADDR_W:0] r;
    assign r = q[ADDR_W:0];
    assign neg = q[ADDR_W+1];
    assign rom_addr = !r[ADDR_W] ? r[ADDR_W-1:0] :
                      (r[ADDR_W-1:0] == '0) ? '1 : ADDR_W'(0) - r[ADDR_W-1:0];
endmodule

// File: rtl/quarter_wave_dds.sv
// quarter_wave_dds: time-multiplexed phase accumulators feeding a quarter-wave ROM address fold (optional DDS_PHASE_SYNC_EN adds sync input)
module quarter_wave_dds
    import dds_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NCH    = NCH_DEF,
    localparam int CW    = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DDS_PHASE_SYNC_EN
    input  logic              sync,
`endif
    input  logic              en,
    input  logic              tw_wr,
    input  logic [CW-1:0]     tw_ch,
    input  logic [ACC_W-1:0]  tw_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              neg,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);
    state_t            state, state_n;
    logic [CW-1:0]     ch_cnt;
    logic [ACC_W-1:0]  phase [NCH];
    logic [ACC_W-1:0]  shadow_tw [NCH];
    logic [ACC_W-1:0]  active_tw [NCH];
    logic              s1_valid;
    logic [CW-1:0]     s1_ch;
    logic [ADDR_W+1:0] s1_q;
    logic [ADDR_W-1:0] fold_addr;
    logic              fold_neg;
    logic              accept, tw_ok, last;

    assign accept = state == IDLE && en;
    assign tw_ok  = tw_wr && int'(tw_ch) < NCH;
    assign last   = ch_cnt == CW'(NCH - 1);
    assign busy   = state == RUN;

    // sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: start a frame on en, finish after the last channel
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (en ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    // tuning-word shadows, frame snapshot, accumulators, pipeline and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                phase[i]     <= '0;
                shadow_tw[i] <= '0;
                active_tw[i] <= '0;
            end
            ch_cnt    <= '0;
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            rom_addr  <= '0;
            neg       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (tw_ok) shadow_tw[tw_ch] <= tw_data;
            if (accept) begin
                ch_cnt <= '0;
                for (int i = 0; i < NCH; i++) begin
                    active_tw[i] <= (tw_ok && tw_ch == CW'(i)) ? tw_data : shadow_tw[i];
`ifdef DDS_PHASE_SYNC_EN
                    if (sync) phase[i] <= '0;
`endif
                end
            end
            if (busy) begin
                ch_cnt        <= ch_cnt + 1'b1;
                phase[ch_cnt] <= phase[ch_cnt] + active_tw[ch_cnt];
            end
            if (busy && en) overrun <= 1'b1;
            s1_valid  <= busy;
            s1_ch     <= ch_cnt;
            s1_q      <= phase[ch_cnt][ACC_W-1 -: ADDR_W+2];
            out_valid <= s1_valid;
            out_ch    <= s1_ch;
            rom_addr  <= fold_addr;
            neg       <= fold_neg;
        end
    end

    quarter_fold #(.ADDR_W(ADDR_W)) u_fold (
        .q        (s1_q),
        .rom_addr (fold_addr),
        .neg      (fold_neg)
    );
endmodule

// File: tb/tb_quarter_wave_dds.sv
// tb_quarter_wave_dds: randomized self-checking bench for quarter_wave_dds against a frame-level phase model
module tb_quarter_wave_dds;
    logic        clk = 1'b0;
    logic        rst, en, tw_wr;
    logic [1:0]  tw_ch;
    logic [23:0] tw_data;
    logic [9:0]  rom_addr;
    logic        neg, out_valid, busy, overrun;
    logic [1:0]  out_ch;
`ifdef DDS_PHASE_SYNC_EN
    logic        sync;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned m_phase[4], m_shadow[4], m_active[4];
    bit m_ovr;
    int last_addr[4];
    bit last_neg[4];

    quarter_wave_dds dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DDS_PHASE_SYNC_EN
        .sync      (sync),
`endif
        .en        (en),
        .tw_wr     (tw_wr),
        .tw_ch     (tw_ch),
        .tw_data   (tw_data),
        .rom_addr  (rom_addr),
        .neg       (neg),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic int exp_addr(input int unsigned p);
        int r;
        r = int'((p >> 12) % 2048);
        return r < 1024 ? r : (r == 1024 ? 1023 : 2048 - r);
    endfunction

    function automatic bit exp_neg(input int unsigned p);
        return p[23];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_phase[c] = 0;
            m_shadow[c] = 0;
            m_active[c] = 0;
        end
        m_ovr = 0;
    endtask

    task automatic apply_reset();
        rst = 1; en = 0; tw_wr = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic write_tw(input int c, input logic [23:0] d);
        tw_wr = 1; tw_ch = 2'(c); tw_data = d;
        m_shadow[c] = d;
        @(negedge clk);
        tw_wr = 0;
    endtask

    task automatic do_frame(input bit sv, input int wr_cyc, input int wr_c, input logic [23:0] wr_d, input int extra_en);
        int unsigned p_exp[4];
        bit ev, eb;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                eb = k >= 1 && k <= 4;
                ev = k >= 3 && k <= 6;
                checks++;
                if (busy !== eb) begin errors++; $display("FAIL busy k=%0d got %b exp %b", k, busy, eb); end
                checks++;
                if (out_valid !== ev) begin errors++; $display("FAIL out_valid k=%0d got %b exp %b", k, out_valid, ev); end
                checks++;
                if (overrun !== m_ovr) begin errors++; $display("FAIL overrun k=%0d got %b exp %b", k, overrun, m_ovr); end
                if (ev) begin
                    checks++;
                    if (out_ch !== 2'(k - 3)) begin errors++; $display("FAIL out_ch k=%0d got %0d exp %0d", k, out_ch, k - 3); end
                    checks++;
                    if (rom_addr !== 10'(exp_addr(p_exp[k-3]))) begin
                        errors++; $display("FAIL rom_addr ch%0d got %0d exp %0d (P=%h)", k - 3, rom_addr, exp_addr(p_exp[k-3]), p_exp[k-3]);
                    end
                    checks++;
                    if (neg !== exp_neg(p_exp[k-3])) begin errors++; $display("FAIL neg ch%0d got %b exp %b", k - 3, neg, exp_neg(p_exp[k-3])); end
                    last_addr[k-3] = int'(rom_addr);
                    last_neg[k-3] = neg;
                end
            end
            en = (k == 0) || (k == extra_en);
`ifdef DDS_PHASE_SYNC_EN
            sync = (k == 0) ? sv : 1'($urandom_range(0, 1));
`endif
            tw_wr = (k == wr_cyc);
            tw_ch = 2'(wr_c);
            tw_data = wr_d;
            if (k == wr_cyc) m_shadow[wr_c] = wr_d;
            if (k == 0) begin
                for (int c = 0; c < 4; c++) begin
                    m_active[c] = m_shadow[c];
`ifdef DDS_PHASE_SYNC_EN
                    if (sv) m_phase[c] = 0;
`endif
                    p_exp[c] = m_phase[c];
                    m_phase[c] = (m_phase[c] + m_active[c]) & 32'h00FF_FFFF;
                end
            end
            if (k == extra_en) m_ovr = 1;
            @(negedge clk);
        end
        en = 0; tw_wr = 0;
`ifdef DDS_PHASE_SYNC_EN
        sync = 0;
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
        checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", neg); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_ramp_wrap();
        int ks[8] = '{0, 1, 1023, 1024, 1025, 1026, 2048, 4096};
        int ea[8] = '{0, 1, 1023, 1023, 1023, 1022, 0, 0};
        bit en_[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        apply_reset();
        write_tw(0, 24'h001000);
        for (int c = 1; c < 4; c++) write_tw(c, 24'($urandom));
        for (int k = 0; k <= 4096; k++) begin
            do_frame(0, -1, 0, 24'h0, -1);
            for (int j = 0; j < 8; j++) begin
                if (ks[j] == k) begin
                    checks++;
                    if (last_addr[0] != ea[j] || last_neg[0] != en_[j]) begin
                        errors++; $display("FAIL ramp k=%0d got addr %0d neg %b exp addr %0d neg %b", k, last_addr[0], last_neg[0], ea[j], en_[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_shadow();
        apply_reset();
        write_tw(0, 24'($urandom));
        do_frame(0, 2, 1, 24'h100000, -1);
        checks++; if (last_addr[1] != 0) begin errors++; $display("FAIL shadow_f1 got %0d exp 0", last_addr[1]); end
        do_frame(0, -1, 0, 24'h0, -1);
        checks++; if (last_addr[1] != 0) begin errors++; $display("FAIL shadow_f2 got %0d exp 0", last_addr[1]); end
        do_frame(0, -1, 0, 24'h0, -1);
        checks++; if (last_addr[1] != 256) begin errors++; $display("FAIL shadow_f3 got %0d exp 256", last_addr[1]); end
    endtask

    task automatic test_coincident();
        for (int i = 0; i < 8; i++) do_frame(0, 0, int'($urandom_range(0, 3)), 24'($urandom), -1);
    endtask

    task automatic test_overrun();
        do_frame(0, -1, 0, 24'h0, int'($urandom_range(1, 4)));
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
        do_frame(0, -1, 0, 24'h0, -1);
    endtask

    task automatic test_rst_mid();
        en = 1;
        @(negedge clk);
        en = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL abort_rom_addr got %0d exp 0", rom_addr); end
        checks++; if (neg !== 1'b0) begin errors++; $display("FAIL abort_neg got %b exp 0", neg); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL abort_out_ch got %0d exp 0", out_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b exp 0", overrun); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid k=%0d got %b exp 0", k, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int wc, xe;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) write_tw(int'($urandom_range(0, 3)), 24'($urandom));
            wc = int'($urandom_range(0, 9)) - 2;
            xe = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1;
            do_frame(0, wc, int'($urandom_range(0, 3)), 24'($urandom), xe);
        end
    endtask

`ifdef DDS_PHASE_SYNC_EN
    task automatic test_sync();
        apply_reset();
        for (int c = 0; c < 4; c++) write_tw(c, 24'($urandom));
        for (int i = 0; i < 50; i++) do_frame(0, -1, 0, 24'h0, -1);
        do_frame(1, -1, 0, 24'h0, -1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (last_addr[c] != 0 || last_neg[c] != 0) begin
                errors++; $display("FAIL sync ch%0d got addr %0d neg %b exp addr 0 neg 0", c, last_addr[c], last_neg[c]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1; en = 0; tw_wr = 0; tw_ch = 0; tw_data = 0;
`ifdef DDS_PHASE_SYNC_EN
        sync = 0;
`endif
        model_reset();
        @(negedge clk);
        test_reset();
        test_ramp_wrap();
        test_shadow();
        test_coincident();
        test_overrun();
        test_rst_mid();
        test_random();
`ifdef DDS_PHASE_SYNC_EN
        test_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
